// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester and the bit-serial adder.
// The requester drives start/a/b; the adder returns busy/done/sum/carry_out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start, a, b,
        input  busy, done, sum, carry_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, carry_out
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder, LSB first. One full-adder cell (two half adders
// plus an OR) is reused every clock, with the carry held in a register between
// bit slices. Operands are captured on start, the result is published with a
// one-cycle done pulse and then held until the next result is ready.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_carryOut;
    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_count;

    logic             w_ha1Sum;
    logic             w_ha1Carry;
    logic             w_ha2Carry;
    logic             w_bitSum;
    logic             w_bitCarry;
    logic [WIDTH-1:0] w_nextA;
    logic [WIDTH-1:0] w_nextB;
    logic [WIDTH-1:0] w_nextAcc;

    // First half adder combines the two operand LSBs.
    half_adder u_ha1 (
        .a (r_opA[0]),
        .b (r_opB[0]),
        .s (w_ha1Sum),
        .c (w_ha1Carry)
    );

    // Second half adder folds in the carry from the previous bit slice.
    half_adder u_ha2 (
        .a (w_ha1Sum),
        .b (r_carry),
        .s (w_bitSum),
        .c (w_ha2Carry)
    );

    assign w_bitCarry = w_ha1Carry | w_ha2Carry;

    // Shift paths: operands move right, the new sum bit enters the result at
    // the MSB. A one-bit adder has nothing left to shift, hence the split.
    generate
        if (WIDTH == 1) begin : g_oneBit
            assign w_nextA   = 1'b0;
            assign w_nextB   = 1'b0;
            assign w_nextAcc = w_bitSum;
        end else begin : g_multiBit
            assign w_nextA   = {1'b0, r_opA[WIDTH-1:1]};
            assign w_nextB   = {1'b0, r_opB[WIDTH-1:1]};
            assign w_nextAcc = {w_bitSum, r_acc[WIDTH-1:1]};
        end
    endgenerate

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carryOut;

    // Control FSM with datapath registers and registered busy/done/result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_opA      <= '0;
            r_opB      <= '0;
            r_acc      <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_carryOut <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_opA   <= bus.a;
                        r_opB   <= bus.b;
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_opA   <= w_nextA;
                    r_opB   <= w_nextB;
                    r_acc   <= w_nextAcc;
                    r_carry <= w_bitCarry;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_STEP) begin
                        r_sum      <= w_nextAcc;
                        r_carryOut <= w_bitCarry;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance for directed,
// back-to-back, reset and random cases, and a 4-bit instance swept over every
// operand pair. Expected results come from plain integer addition.
module tb_serial_adder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [7:0] a, input logic [7:0] b);
        bus8.start = s;
        bus8.a     = a;
        bus8.b     = b;
    endtask

    // One complete 8-bit add with random junk on start/a/b while busy.
    task automatic runAdd8(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [8:0] expv;
        logic [8:0] held;
        int         busyN;
        logic       stable;
        expv = 9'(a) + 9'(b);
        held = {bus8.carry_out, bus8.sum};
        applyStimulus(1'b1, a, b);
        tick();
        busyN  = 0;
        stable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (bus8.busy === 1'b1) busyN++;
            if ({bus8.carry_out, bus8.sum} !== held || bus8.done !== 1'b0) stable = 1'b0;
            applyStimulus(1'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        bus8.start = 1'b0;
        checkOutput({tag, " busy cycles"}, 64'(busyN), 64'd8);
        checkOutput({tag, " quiet while busy"}, 64'(stable), 64'd1);
        checkOutput({tag, " done"}, 64'(bus8.done), 64'd1);
        checkOutput({tag, " result"}, 64'({bus8.carry_out, bus8.sum}), 64'(expv));
        tick();
        checkOutput({tag, " done width"}, 64'({bus8.done, bus8.busy}), 64'd0);
        checkOutput({tag, " result held"}, 64'({bus8.carry_out, bus8.sum}), 64'(expv));
    endtask

    // One complete 4-bit add; folds timing checks into flags to keep the sweep short.
    task automatic runAdd4(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] expv;
        logic [4:0] held;
        int         busyN;
        logic       stable;
        expv = 5'(a) + 5'(b);
        held = {bus4.carry_out, bus4.sum};
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        tick();
        bus4.start = 1'b0;
        busyN  = 0;
        stable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (bus4.busy === 1'b1) busyN++;
            if ({bus4.carry_out, bus4.sum} !== held || bus4.done !== 1'b0) stable = 1'b0;
            bus4.a = 4'($urandom);
            bus4.b = 4'($urandom);
            tick();
        end
        if (bus4.done !== 1'b1 || busyN != 4) stable = 1'b0;
        checkOutput($sformatf("w4 %0d+%0d result", a, b),
                    64'({bus4.carry_out, bus4.sum}), 64'(expv));
        tick();
        if (bus4.done !== 1'b0 || {bus4.carry_out, bus4.sum} !== expv) stable = 1'b0;
        checkOutput($sformatf("w4 %0d+%0d timing", a, b), 64'(stable), 64'd1);
    endtask

    // Directed sequence followed by random and exhaustive sweeps.
    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         doneN;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00);
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        tick();
        tick();
        checkOutput("reset outputs", 64'({bus8.busy, bus8.done, bus8.carry_out, bus8.sum}), 64'd0);
        #2 rst_n = 1'b1;
        tick();
        checkOutput("idle after reset", 64'({bus8.busy, bus8.done}), 64'd0);

        runAdd8(8'h00, 8'h00, "00+00");
        runAdd8(8'hFF, 8'h01, "FF+01");
        runAdd8(8'hA5, 8'h5A, "A5+5A");
        runAdd8(8'h80, 8'h80, "80+80");

        // Back-to-back: start stays high, second operands taken in the DONE cycle.
        applyStimulus(1'b1, 8'h12, 8'h34);
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom));
            tick();
        end
        checkOutput("b2b first done", 64'(bus8.done), 64'd1);
        checkOutput("b2b first sum", 64'({bus8.carry_out, bus8.sum}), 64'h046);
        applyStimulus(1'b1, 8'h0F, 8'h01);
        tick();
        checkOutput("b2b accepted in done", 64'({bus8.busy, bus8.done}), 64'b10);
        checkOutput("b2b sum unchanged by start", 64'(bus8.sum), 64'h46);
        doneN = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus8.done === 1'b1) doneN++;
            applyStimulus(1'b1, 8'($urandom), 8'($urandom));
            tick();
        end
        bus8.start = 1'b0;
        checkOutput("b2b no early done", 64'(doneN), 64'd0);
        checkOutput("b2b second done", 64'(bus8.done), 64'd1);
        checkOutput("b2b second sum", 64'({bus8.carry_out, bus8.sum}), 64'h010);
        tick();
        checkOutput("b2b back to idle", 64'({bus8.busy, bus8.done}), 64'd0);

        // Asynchronous reset in the middle of an add.
        applyStimulus(1'b1, 8'hFF, 8'hFF);
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset clears", 64'({bus8.busy, bus8.done, bus8.carry_out, bus8.sum}), 64'd0);
        tick();
        #2 rst_n = 1'b1;
        doneN = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) doneN++;
            tick();
        end
        checkOutput("no done after reset", 64'(doneN), 64'd0);
        runAdd8(8'h03, 8'h04, "03+04");

        for (int n = 0; n < 16; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            runAdd8(ra, rb, $sformatf("rand %02h+%02h", ra, rb));
        end

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                runAdd4(4'(x), 4'(y));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder, LSB first.
- Built from two half_adder instances plus an OR gate, forming a full adder, with a registered carry between bit slices.
- Accepts two operands on a start handshake and shifts them through the single adder cell, one bit per clock.
- Presents the registered sum and carry-out with a one-cycle done pulse. It is the sequential consumer stage of the half_adder cell.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to add a and b; sampled on rising clk.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while a serial add is in progress.
- done  output  1  one-cycle pulse: sum and carry_out are valid.
- sum  output  WIDTH  registered result, (a+b) mod 2^WIDTH.
- carry_out  output  1  registered carry out of the MSB.

Behaviour:
- Reset: rst_n low asynchronously forces:
  - state=IDLE
  - busy=0, done=0, sum=0, carry_out=0
  - operand shift regs=0, carry reg=0, bit counter=0
  Reset is effective mid-operation; the partial result is discarded and no done is issued.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: start=1 -> load a and b into shift regs, clear carry reg and counter, go to SHIFT. start=0 -> stay in IDLE.
  - SHIFT: each edge performs one bit step:
    - s = a0^b0^c; c' = a0&b0 | c&(a0^b0)
    - s enters the result reg at the MSB (shift right); operand regs shift right; counter increments.
    - On the edge where counter = WIDTH-1 (the WIDTH-th step), go to DONE and load sum = the final result and carry_out = c'.
  - DONE: lasts exactly one cycle. start=1 -> accept the new operands exactly as in IDLE and go to SHIFT (back-to-back operation). Otherwise go to IDLE.
- Outputs are all registered; there is no combinational path from inputs to outputs.
  - busy = (state==SHIFT).
  - done = (state==DONE).
- Latency: with start accepted at edge E0, done is high for the cycle between edges E(WIDTH) and E(WIDTH+1). Throughput is one add per WIDTH+1 cycles.
- sum and carry_out hold their value until the next DONE entry. They do not change during SHIFT and do not change on start.
- start while busy=1 is ignored, with no effect on the operation in flight. a and b are don't-care except on the accepting edge.
- Arithmetic: unsigned. {carry_out,sum} = a+b exactly; the carry-in of bit 0 is 0.
- WIDTH=1: SHIFT lasts one cycle; done is high in the cycle after E1.

Test Plan:
- WIDTH=8: reset, then start with a=0x00, b=0x00 -> busy high for 8 cycles; done pulses once at E8; sum=0x00, carry_out=0.
- a=0xFF, b=0x01 -> sum=0x00, carry_out=1. a=0xA5, b=0x5A -> sum=0xFF, carry_out=0. a=0x80, b=0x80 -> sum=0x00, carry_out=1.
- start held high throughout, first operands a=0x12, b=0x34, second a=0x0F, b=0x01:
  - sum=0x46 at first done; second add accepted in the DONE cycle.
  - sum=0x10 at the next done, 9 cycles later.
  - Values applied on a/b while busy are ignored.
- rst_n pulled low at cycle 4 of an add of 0xFF+0xFF -> busy, done, sum and carry_out go to 0 immediately with no clk edge; no done afterwards. A fresh add of 0x03+0x04 then gives sum=0x07.
- Exhaustive check with WIDTH=4: all 256 a/b pairs, each compared {carry_out,sum} against a+b. Also check done is exactly one cycle wide and sum is stable between dones.
